// File: rtl/stream_playback.sv
// stream_playback: replays a contiguous memory region as a single AXI-stream frame.
// Ports: start/start_addr/byte_len launch a transfer and busy/done/error report on it;
//        axi_ar*/axi_r* form a single-beat AXI4 read master; m_axis_* carries the frame out.

// Generic synchronous FIFO, used here as the landing buffer for read data.
// Latency: an accepted write is visible on the read side one cycle later.
// Backpressure: a write while full is dropped; the writer must hold credit so that never occurs.
module sp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_vld_i,
    input  logic [WIDTH-1:0]           wr_dat_i,
    output logic                       rd_vld_o,
    output logic [WIDTH-1:0]           rd_dat_o,
    input  logic                       rd_rdy_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CNTW-1:0]  count_q;
    logic             wr_en;
    logic             rd_en;

    assign wr_en    = wr_vld_i && (count_q != CNTW'(DEPTH));
    assign rd_en    = rd_rdy_i && (count_q != '0);
    assign rd_vld_o = (count_q != '0);
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign count_o  = count_q;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CNTW'(wr_en) - CNTW'(rd_en);
        end
    end
endmodule

// Memory-to-stream playback: one single-beat AR per 64-byte beat, data re-emitted as one frame.
// Latency: first AR the cycle after start; an R beat reaches m_axis one cycle after acceptance.
// Backpressure: m_axis_tready stalls AR issue through credits; R is never back-pressured.
module stream_playback #(
    parameter int DATA_WIDTH      = 512,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH      = 34,
    parameter int LEN_WIDTH       = 32,
    parameter int FIFO_DEPTH      = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  s_axis_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  byte_len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [5:0]            axi_arid,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic [2:0]            axi_arsize,
    output logic [1:0]            axi_arburst,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);
    localparam int OFFW = $clog2(KEEP_WIDTH);
    localparam int CW   = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int ENTW = DATA_WIDTH + KEEP_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [LEN_WIDTH-1:0]  total_q;
    logic [LEN_WIDTH-1:0]  issued_q;
    logic [LEN_WIDTH-1:0]  recv_q;
    logic [OFFW-1:0]       rem_q;
    logic [CW-1:0]         out_q;
    logic                  arvalid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;

    logic                  ar_hs;
    logic                  r_hs;
    logic                  pop_hs;
    logic                  frame_end;
    logic                  can_issue;
    logic                  last_beat;
    logic [CW-1:0]         out_d;
    logic [CW-1:0]         fcnt_d;
    logic [LEN_WIDTH-1:0]  issued_d;
    logic [LEN_WIDTH-1:0]  total_len;
    logic [KEEP_WIDTH-1:0] beat_keep;
    logic [CNTW-1:0]       fifo_count;
    logic                  fifo_vld;
    logic [ENTW-1:0]       fifo_dat;
    logic                  unused_ok;

    assign ar_hs     = arvalid_q & axi_arready;
    assign r_hs      = axi_rvalid & busy_q;
    assign pop_hs    = fifo_vld & m_axis_tready;
    assign frame_end = pop_hs & fifo_dat[0];

    // Shift first, then add the partial-beat bit, so byte_len = 2^LEN_WIDTH-1 cannot overflow.
    assign total_len = (byte_len >> OFFW) + LEN_WIDTH'(|byte_len[OFFW-1:0]);

    // Credit is judged on the post-edge counts so back-to-back ARs keep arvalid high.
    // While an AR waits for arready the sum outstanding+fifo can only shrink, so the
    // decision taken when arvalid rose stays valid until acceptance.
    assign out_d     = out_q + CW'(ar_hs) - CW'(r_hs);
    assign fcnt_d    = CW'(fifo_count) + CW'(r_hs) - CW'(pop_hs);
    assign issued_d  = issued_q + LEN_WIDTH'(ar_hs);
    assign can_issue = (issued_d < total_q)
                    && ((out_d + fcnt_d) < CW'(FIFO_DEPTH))
                    && (out_d < CW'(MAX_OUTSTANDING));

    always_comb begin
        last_beat = ((recv_q + LEN_WIDTH'(1)) == total_q);
        beat_keep = '1;
        if (last_beat && (rem_q != '0)) begin
            for (int i = 0; i < KEEP_WIDTH; i++) begin
                beat_keep[i] = (OFFW'(i) < rem_q);
            end
        end
    end

    sp_fifo #(
        .WIDTH (ENTW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (s_axis_clk),
        .rst_i    (rst),
        .wr_vld_i (r_hs),
        .wr_dat_i ({axi_rdata, beat_keep, last_beat}),
        .rd_vld_o (fifo_vld),
        .rd_dat_o (fifo_dat),
        .rd_rdy_i (m_axis_tready),
        .count_o  (fifo_count)
    );

    always_ff @(posedge s_axis_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            araddr_q  <= '0;
            total_q   <= '0;
            issued_q  <= '0;
            recv_q    <= '0;
            rem_q     <= '0;
            out_q     <= '0;
            arvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // FINISH already reports busy=0, so it accepts a new start like IDLE.
                S_IDLE, S_FINISH: begin
                    state_q <= S_IDLE;
                    if (start) begin
                        error_q <= 1'b0;
                        if (byte_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q   <= S_RUN;
                            busy_q    <= 1'b1;
                            araddr_q  <= {start_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                            total_q   <= total_len;
                            issued_q  <= '0;
                            recv_q    <= '0;
                            rem_q     <= byte_len[OFFW-1:0];
                            out_q     <= '0;
                            // Buffer is empty and nothing is in flight, so the first AR has credit.
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (ar_hs) araddr_q <= araddr_q + ADDR_WIDTH'(KEEP_WIDTH);
                    issued_q  <= issued_d;
                    out_q     <= out_d;
                    arvalid_q <= (arvalid_q && !axi_arready) || can_issue;
                    if (r_hs) begin
                        recv_q <= recv_q + LEN_WIDTH'(1);
                        if (axi_rresp != 2'b00) error_q <= 1'b1;
                    end
                    if (frame_end) begin
                        state_q   <= S_FINISH;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        arvalid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign axi_arid      = '0;
    assign axi_araddr    = araddr_q;
    assign axi_arlen     = '0;
    assign axi_arsize    = 3'd6;
    assign axi_arburst   = 2'b01;
    assign axi_arvalid   = arvalid_q;
    assign axi_rready    = busy_q;
    // The buffer RAM is not reset, so payload is forced to zero whenever no beat is presented.
    assign m_axis_tvalid = fifo_vld;
    assign m_axis_tdata  = fifo_vld ? fifo_dat[ENTW-1 -: DATA_WIDTH] : '0;
    assign m_axis_tkeep  = fifo_vld ? fifo_dat[KEEP_WIDTH:1] : '0;
    assign m_axis_tlast  = fifo_vld & fifo_dat[0];

    // Every read is single-beat and the low address bits are forced to zero.
    assign unused_ok = &{1'b0, axi_rlast, start_addr[OFFW-1:0]};
endmodule
